// File: rtl/test002_if.sv
// Call/return bundle for test002: external array port, x/y field access and the
// nine method req/busy/argument/return groups.
interface test002_if;
  logic [31:0] a_address;
  logic        a_we;
  logic        a_oe;
  logic [31:0] a_din;
  logic [31:0] a_dout;
  logic [31:0] a_length;
  logic [31:0] x_in, y_in, x_out, y_out;
  logic        x_we, y_we;
  logic [31:0] dec_i, inc_i, get_i, switch_test_x;
  logic [31:0] copy_i, copy_j, set_i, set_v;
  logic        init_req, dec_req, inc_req, copy_req, set_req;
  logic        get_req, switch_test_req, sum_x_y_req, test_req;
  logic        init_busy, dec_busy, inc_busy, copy_busy, set_busy;
  logic        get_busy, switch_test_busy, sum_x_y_busy, test_busy;
  logic [31:0] dec_return, inc_return, get_return, switch_test_return, sum_x_y_return;
  logic        test_return;

  modport slave (
    input  a_address, a_we, a_oe, a_din, x_in, y_in, x_we, y_we,
           dec_i, inc_i, get_i, switch_test_x, copy_i, copy_j, set_i, set_v,
           init_req, dec_req, inc_req, copy_req, set_req,
           get_req, switch_test_req, sum_x_y_req, test_req,
    output a_dout, a_length, x_out, y_out,
           init_busy, dec_busy, inc_busy, copy_busy, set_busy,
           get_busy, switch_test_busy, sum_x_y_busy, test_busy,
           dec_return, inc_return, get_return, switch_test_return, sum_x_y_return,
           test_return
  );

  modport master (
    output a_address, a_we, a_oe, a_din, x_in, y_in, x_we, y_we,
           dec_i, inc_i, get_i, switch_test_x, copy_i, copy_j, set_i, set_v,
           init_req, dec_req, inc_req, copy_req, set_req,
           get_req, switch_test_req, sum_x_y_req, test_req,
    input  a_dout, a_length, x_out, y_out,
           init_busy, dec_busy, inc_busy, copy_busy, set_busy,
           get_busy, switch_test_busy, sum_x_y_busy, test_busy,
           dec_return, inc_return, get_return, switch_test_return, sum_x_y_return,
           test_return
  );
endinterface

// File: rtl/test002.sv
// Method-call compute object: 128-word array plus x/y fields, one method at a time.
// The test method replays a fixed call script through the same method states.
module test002 #(
  parameter int A_DEPTH = 128
) (
  input logic      clk,
  input logic      reset,
  test002_if.slave bus
);
  localparam int AW = $clog2(A_DEPTH);

  localparam logic [3:0] S_IDLE = 4'd0,  S_INIT = 4'd1,   S_INIT_END = 4'd2, S_DEC = 4'd3,
                         S_INC  = 4'd4,  S_CPY_RD = 4'd5, S_CPY_WR = 4'd6,  S_SET = 4'd7,
                         S_GET_RD = 4'd8, S_GET_WR = 4'd9, S_SW = 4'd10,     S_SUM = 4'd11,
                         S_TEST = 4'd12;

  localparam int B_INIT = 0, B_DEC = 1, B_INC = 2, B_COPY = 3, B_SET = 4,
                 B_GET = 5, B_SW = 6, B_SUM = 7, B_TEST = 8;

  logic [31:0]   r_mem [A_DEPTH];
  logic [3:0]    r_state;
  logic [8:0]    r_busy;
  logic [AW-1:0] r_cnt;
  logic [31:0]   r_op_a, r_op_b, r_rd, r_x, r_y, r_a_dout, r_texp;
  logic [31:0]   r_dec_ret, r_inc_ret, r_get_ret, r_sw_ret, r_sum_ret;
  logic          r_test_ret, r_in_test, r_tok;
  logic [3:0]    r_tstep;

  logic          w_int_we;
  logic [AW-1:0] w_int_addr;
  logic [31:0]   w_int_data;
  logic [31:0]   w_res;
  logic          w_res_valid;
  logic [3:0]    w_done_state;

  function automatic logic [31:0] sw_map(input logic [31:0] v);
    case (v)
      32'd0:   sw_map = 32'd10;
      32'd1:   sw_map = 32'd20;
      32'd2:   sw_map = 32'd30;
      32'd3:   sw_map = 32'd40;
      default: sw_map = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Internal write port and the value produced by the completing method.
  always_comb begin
    w_int_we    = 1'b0;
    w_int_addr  = '0;
    w_int_data  = 32'd0;
    w_res       = 32'd0;
    w_res_valid = 1'b0;
    case (r_state)
      S_INIT:   begin w_int_we = 1'b1; w_int_addr = r_cnt; end
      S_CPY_WR: begin w_int_we = 1'b1; w_int_addr = r_op_b[AW-1:0]; w_int_data = r_rd; end
      S_SET:    begin w_int_we = 1'b1; w_int_addr = r_op_a[AW-1:0]; w_int_data = r_op_b; end
      S_DEC:    begin w_res = r_op_a - 32'd1; w_res_valid = 1'b1; end
      S_INC:    begin w_res = r_op_a + 32'd1; w_res_valid = 1'b1; end
      S_GET_WR: begin w_res = r_rd;           w_res_valid = 1'b1; end
      S_SW:     begin w_res = sw_map(r_op_a); w_res_valid = 1'b1; end
      S_SUM:    begin w_res = r_x + r_y;      w_res_valid = 1'b1; end
      default:  begin w_int_we = 1'b0; end
    endcase
    if (r_in_test) begin
      w_done_state = S_TEST;
    end else begin
      w_done_state = S_IDLE;
    end
  end

  // Array storage; not reset. The internal write is last so it wins on the same word.
  always_ff @(posedge clk) begin
    if (bus.a_we) r_mem[bus.a_address[AW-1:0]] <= bus.a_din;
    if (w_int_we) r_mem[w_int_addr] <= w_int_data;
  end

  // External read port: one-cycle latency, holds when a_oe is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_a_dout <= 32'd0;
    else if (bus.a_oe) r_a_dout <= r_mem[bus.a_address[AW-1:0]];
  end

  // Method sequencer, fields and returns. Calls made by test also update their returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;  r_busy <= 9'd0;    r_cnt <= '0;
      r_op_a <= 32'd0;    r_op_b <= 32'd0;   r_rd <= 32'd0;
      r_x <= 32'd0;       r_y <= 32'd0;      r_texp <= 32'd0;
      r_dec_ret <= 32'd0; r_inc_ret <= 32'd0; r_get_ret <= 32'd0;
      r_sw_ret <= 32'd0;  r_sum_ret <= 32'd0; r_test_ret <= 1'b0;
      r_in_test <= 1'b0;  r_tok <= 1'b0;     r_tstep <= 4'd0;
    end else begin
      if (bus.x_we) r_x <= bus.x_in;
      if (bus.y_we) r_y <= bus.y_in;
      if (r_in_test && w_res_valid && (w_res != r_texp)) r_tok <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.test_req) begin
            r_state <= S_TEST; r_busy[B_TEST] <= 1'b1;
            r_in_test <= 1'b1; r_tstep <= 4'd0; r_tok <= 1'b1;
          end else if (bus.init_req) begin
            r_state <= S_INIT; r_busy[B_INIT] <= 1'b1; r_cnt <= '0;
          end else if (bus.set_req) begin
            r_state <= S_SET; r_busy[B_SET] <= 1'b1; r_op_a <= bus.set_i; r_op_b <= bus.set_v;
          end else if (bus.copy_req) begin
            r_state <= S_CPY_RD; r_busy[B_COPY] <= 1'b1; r_op_a <= bus.copy_i; r_op_b <= bus.copy_j;
          end else if (bus.get_req) begin
            r_state <= S_GET_RD; r_busy[B_GET] <= 1'b1; r_op_a <= bus.get_i;
          end else if (bus.inc_req) begin
            r_state <= S_INC; r_busy[B_INC] <= 1'b1; r_op_a <= bus.inc_i;
          end else if (bus.dec_req) begin
            r_state <= S_DEC; r_busy[B_DEC] <= 1'b1; r_op_a <= bus.dec_i;
          end else if (bus.switch_test_req) begin
            r_state <= S_SW; r_busy[B_SW] <= 1'b1; r_op_a <= bus.switch_test_x;
          end else if (bus.sum_x_y_req) begin
            r_state <= S_SUM; r_busy[B_SUM] <= 1'b1;
          end
        end
        S_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(A_DEPTH - 1)) r_state <= S_INIT_END;
        end
        S_INIT_END: begin r_busy[B_INIT] <= 1'b0; r_state <= w_done_state; end
        S_SET:      begin r_busy[B_SET]  <= 1'b0; r_state <= w_done_state; end
        S_CPY_RD:   begin r_rd <= r_mem[r_op_a[AW-1:0]]; r_state <= S_CPY_WR; end
        S_CPY_WR:   begin r_busy[B_COPY] <= 1'b0; r_state <= w_done_state; end
        S_GET_RD:   begin r_rd <= r_mem[r_op_a[AW-1:0]]; r_state <= S_GET_WR; end
        S_GET_WR:   begin r_get_ret <= w_res; r_busy[B_GET] <= 1'b0; r_state <= w_done_state; end
        S_INC:      begin r_inc_ret <= w_res; r_busy[B_INC] <= 1'b0; r_state <= w_done_state; end
        S_DEC:      begin r_dec_ret <= w_res; r_busy[B_DEC] <= 1'b0; r_state <= w_done_state; end
        S_SW:       begin r_sw_ret  <= w_res; r_busy[B_SW]  <= 1'b0; r_state <= w_done_state; end
        S_SUM:      begin r_sum_ret <= w_res; r_busy[B_SUM] <= 1'b0; r_state <= w_done_state; end
        S_TEST: begin
          // One script step per visit; value-returning calls load the expected result.
          r_tstep <= r_tstep + 4'd1;
          case (r_tstep)
            4'd0: begin r_state <= S_INIT; r_busy[B_INIT] <= 1'b1; r_cnt <= '0; end
            4'd1: begin r_state <= S_SET; r_busy[B_SET] <= 1'b1; r_op_a <= 32'd3; r_op_b <= 32'd50; end
            4'd2: begin r_state <= S_CPY_RD; r_busy[B_COPY] <= 1'b1; r_op_a <= 32'd3; r_op_b <= 32'd4; end
            4'd3: begin r_state <= S_GET_RD; r_busy[B_GET] <= 1'b1; r_op_a <= 32'd4; r_texp <= 32'd50; end
            4'd4: begin r_x <= 32'd10; r_y <= 32'd20; end
            4'd5: begin r_state <= S_SUM; r_busy[B_SUM] <= 1'b1; r_texp <= 32'd30; end
            4'd6: begin r_state <= S_INC; r_busy[B_INC] <= 1'b1; r_op_a <= 32'd5; r_texp <= 32'd6; end
            4'd7: begin r_state <= S_DEC; r_busy[B_DEC] <= 1'b1; r_op_a <= 32'd5; r_texp <= 32'd4; end
            4'd8: begin r_state <= S_SW; r_busy[B_SW] <= 1'b1; r_op_a <= 32'd2; r_texp <= 32'd30; end
            4'd9: begin r_state <= S_SW; r_busy[B_SW] <= 1'b1; r_op_a <= 32'd9; r_texp <= 32'hFFFF_FFFF; end
            default: begin
              r_test_ret <= r_tok; r_busy[B_TEST] <= 1'b0;
              r_in_test <= 1'b0;   r_state <= S_IDLE;
            end
          endcase
        end
        default: begin r_state <= S_IDLE; r_busy <= 9'd0; r_in_test <= 1'b0; end
      endcase
    end
  end

  assign bus.a_dout             = r_a_dout;
  assign bus.a_length           = 32'(A_DEPTH);
  assign bus.x_out              = r_x;
  assign bus.y_out              = r_y;
  assign bus.init_busy          = r_busy[B_INIT];
  assign bus.dec_busy           = r_busy[B_DEC];
  assign bus.inc_busy           = r_busy[B_INC];
  assign bus.copy_busy          = r_busy[B_COPY];
  assign bus.set_busy           = r_busy[B_SET];
  assign bus.get_busy           = r_busy[B_GET];
  assign bus.switch_test_busy   = r_busy[B_SW];
  assign bus.sum_x_y_busy       = r_busy[B_SUM];
  assign bus.test_busy          = r_busy[B_TEST];
  assign bus.dec_return         = r_dec_ret;
  assign bus.inc_return         = r_inc_ret;
  assign bus.get_return         = r_get_ret;
  assign bus.switch_test_return = r_sw_ret;
  assign bus.sum_x_y_return     = r_sum_ret;
  assign bus.test_return        = r_test_ret;
endmodule

// File: tb/tb_test002.sv
// Directed-vector bench for test002 with hand-computed expectations.
module tb_test002;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   ncyc;
  logic [31:0] rd;

  localparam int M_INIT = 0, M_DEC = 1, M_INC = 2, M_COPY = 3, M_SET = 4,
                 M_GET = 5, M_SW = 6, M_SUM = 7, M_TEST = 8;

  test002_if bus();
  test002 dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int m, input logic v);
    case (m)
      M_INIT: bus.init_req = v;
      M_DEC:  bus.dec_req = v;
      M_INC:  bus.inc_req = v;
      M_COPY: bus.copy_req = v;
      M_SET:  bus.set_req = v;
      M_GET:  bus.get_req = v;
      M_SW:   bus.switch_test_req = v;
      M_SUM:  bus.sum_x_y_req = v;
      default: bus.test_req = v;
    endcase
  endtask

  function automatic logic busy_of(input int m);
    case (m)
      M_INIT:  return bus.init_busy;
      M_DEC:   return bus.dec_busy;
      M_INC:   return bus.inc_busy;
      M_COPY:  return bus.copy_busy;
      M_SET:   return bus.set_busy;
      M_GET:   return bus.get_busy;
      M_SW:    return bus.switch_test_busy;
      M_SUM:   return bus.sum_x_y_busy;
      default: return bus.test_busy;
    endcase
  endfunction

  // Issue a call, count the busy cycles (bounded). With hold, req stays high until busy falls.
  task automatic call_m(input int m, input bit hold, input int budget, output int nc);
    nc = 0;
    @(negedge clk); set_req(m, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_req(m, 1'b0);
    @(negedge clk);
    while (busy_of(m) && nc < budget) begin
      nc++;
      @(negedge clk);
    end
    set_req(m, 1'b0);
  endtask

  task automatic ext_wr(input logic [31:0] addr, input logic [31:0] d);
    @(negedge clk); bus.a_address = addr; bus.a_din = d; bus.a_we = 1'b1;
    @(negedge clk); bus.a_we = 1'b0;
  endtask

  task automatic ext_rd(input logic [31:0] addr, output logic [31:0] d);
    @(negedge clk); bus.a_address = addr; bus.a_oe = 1'b1;
    @(negedge clk); bus.a_oe = 1'b0; d = bus.a_dout;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.a_address = 32'd0; bus.a_we = 1'b0; bus.a_oe = 1'b0; bus.a_din = 32'd0;
    bus.x_in = 32'd0; bus.y_in = 32'd0; bus.x_we = 1'b0; bus.y_we = 1'b0;
    bus.dec_i = 32'd0; bus.inc_i = 32'd0; bus.get_i = 32'd0; bus.switch_test_x = 32'd0;
    bus.copy_i = 32'd0; bus.copy_j = 32'd0; bus.set_i = 32'd0; bus.set_v = 32'd0;
    for (int m = 0; m < 9; m++) set_req(m, 1'b0);

    repeat (6) @(negedge clk);
    chk("rst_busy", 32'({bus.init_busy, bus.dec_busy, bus.inc_busy, bus.copy_busy, bus.set_busy,
                         bus.get_busy, bus.switch_test_busy, bus.sum_x_y_busy, bus.test_busy}), 32'd0);
    chk("rst_returns", bus.dec_return | bus.inc_return | bus.get_return |
                       bus.switch_test_return | bus.sum_x_y_return, 32'd0);
    chk("rst_test_return", 32'(bus.test_return), 32'd0);
    chk("rst_xy", bus.x_out | bus.y_out, 32'd0);
    chk("rst_a_dout", bus.a_dout, 32'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);

    // Self-test with req held until busy falls.
    @(negedge clk); bus.test_req = 1'b1;
    @(negedge clk);
    chk("test_busy_rise", 32'(bus.test_busy), 32'd1);
    ncyc = 1;
    while (bus.test_busy && ncyc < 400) begin ncyc++; @(negedge clk); end
    bus.test_req = 1'b0;
    chk("test_latency_lt200", 32'(ncyc < 200), 32'd1);
    chk("test_return", 32'(bus.test_return), 32'd1);
    chk("test_x", bus.x_out, 32'd10);
    chk("test_y", bus.y_out, 32'd20);
    repeat (3) @(negedge clk);
    chk("test_no_rerun", 32'(bus.test_busy), 32'd0);
    ext_rd(32'd3, rd); chk("test_a3", rd, 32'd50);
    ext_rd(32'd4, rd); chk("test_a4", rd, 32'd50);

    // inc/dec wrap.
    bus.inc_i = 32'hFFFF_FFFF;
    call_m(M_INC, 1'b0, 10, ncyc);
    chk("inc_busy_cycles", ncyc, 32'd1);
    chk("inc_wrap", bus.inc_return, 32'd0);
    bus.dec_i = 32'd0;
    call_m(M_DEC, 1'b0, 10, ncyc);
    chk("dec_busy_cycles", ncyc, 32'd1);
    chk("dec_wrap", bus.dec_return, 32'hFFFF_FFFF);

    // set / get / external read; index is taken mod 128.
    bus.set_i = 32'd7; bus.set_v = 32'h0000_1234;
    call_m(M_SET, 1'b0, 10, ncyc);
    chk("set_busy_cycles", ncyc, 32'd1);
    bus.get_i = 32'd135;
    call_m(M_GET, 1'b0, 10, ncyc);
    chk("get_busy_cycles", ncyc, 32'd2);
    chk("get_a7", bus.get_return, 32'h0000_1234);
    ext_rd(32'd7, rd); chk("ext_rd_a7", rd, 32'h0000_1234);

    // copy a[7] -> a[8].
    bus.copy_i = 32'd7; bus.copy_j = 32'd8;
    call_m(M_COPY, 1'b0, 10, ncyc);
    chk("copy_busy_cycles", ncyc, 32'd2);
    ext_rd(32'd8, rd); chk("copy_a8", rd, 32'h0000_1234);

    // switch_test table.
    bus.switch_test_x = 32'd0; call_m(M_SW, 1'b0, 10, ncyc); chk("sw_0", bus.switch_test_return, 32'd10);
    bus.switch_test_x = 32'd1; call_m(M_SW, 1'b0, 10, ncyc); chk("sw_1", bus.switch_test_return, 32'd20);
    bus.switch_test_x = 32'd3; call_m(M_SW, 1'b0, 10, ncyc); chk("sw_3", bus.switch_test_return, 32'd40);
    bus.switch_test_x = 32'd4; call_m(M_SW, 1'b0, 10, ncyc); chk("sw_4", bus.switch_test_return, 32'hFFFF_FFFF);

    // Field strobes then sum.
    @(negedge clk); bus.x_in = 32'd5; bus.y_in = 32'd7; bus.x_we = 1'b1; bus.y_we = 1'b1;
    @(negedge clk); bus.x_we = 1'b0; bus.y_we = 1'b0;
    chk("x_we", bus.x_out, 32'd5);
    chk("y_we", bus.y_out, 32'd7);
    call_m(M_SUM, 1'b0, 10, ncyc);
    chk("sum_x_y", bus.sum_x_y_return, 32'd12);

    // Priority: inc beats dec when requested together.
    bus.inc_i = 32'h0000_0041;
    @(negedge clk); bus.inc_req = 1'b1; bus.dec_req = 1'b1;
    @(posedge clk); #1 bus.inc_req = 1'b0; bus.dec_req = 1'b0;
    @(negedge clk);
    chk("prio_busy_inc_dec", 32'({bus.inc_busy, bus.dec_busy}), 32'd2);
    @(negedge clk);
    chk("prio_inc_ret", bus.inc_return, 32'h0000_0042);
    chk("prio_dec_untouched", bus.dec_return, 32'hFFFF_FFFF);

    // init clears the array, 129 busy cycles.
    ext_wr(32'd10, 32'd9);
    ext_rd(32'd10, rd); chk("ext_wr_a10", rd, 32'd9);
    call_m(M_INIT, 1'b0, 300, ncyc);
    chk("init_busy_cycles", ncyc, 32'd129);
    ext_rd(32'd10, rd); chk("init_a10", rd, 32'd0);
    ext_rd(32'd127, rd); chk("init_a127", rd, 32'd0);
    ext_rd(32'd7, rd); chk("init_a7", rd, 32'd0);
    chk("a_length", bus.a_length, 32'd128);

    // Reset in the middle of init aborts immediately.
    ext_wr(32'd100, 32'hDEAD_BEEF);
    @(negedge clk); bus.init_req = 1'b1;
    @(posedge clk); #1 bus.init_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("init_busy_mid", 32'(bus.init_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_abort_busy", 32'(bus.init_busy), 32'd0);
    chk("reset_clears_dec", bus.dec_return, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ext_rd(32'd100, rd); chk("partial_init_kept", rd, 32'hDEAD_BEEF);
    call_m(M_TEST, 1'b0, 400, ncyc);
    chk("retest_latency_lt200", 32'(ncyc < 200), 32'd1);
    chk("retest_return", 32'(bus.test_return), 32'd1);
    chk("a_length_end", bus.a_length, 32'd128);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
